inv_chain_monitor: RTL and testbench

Clocked measurement stage that sits directly downstream of the 3-inverter chain and consumes its `out` net. It synchronises the chain output into the `clk` domain, detects edges, and measures each high/low pulse width in clock cycles. Per edge it reports one measurement (level, width, glitch flag) and keeps a running edge count. Testbenches use it to check the chain's propagation and toggle behaviour without inspecting VCD dumps.

---
 rtl/inv_mon_pkg.sv | 19 +
 rtl/inv_chain_monitor_sync2.sv | 33 +++
 rtl/inv_chain_monitor.sv | 143 ++++++++++++++
 tb/tb_inv_chain_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/inv_mon_pkg.sv
// ---------------------------------------------------------------------------
// inv_mon_pkg
// Shared definitions for the inverter-chain pulse monitor:
//   - mon_state_t : measurement FSM states (WAIT, HIGH, LOW)
//   - *_DEF       : default parameter values for the monitor top
// ---------------------------------------------------------------------------
package inv_mon_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int EDGE_W_DEF = 16;
    localparam int MIN_W_DEF  = 2;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } mon_state_t;

endpackage

// File: rtl/inv_chain_monitor_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
// Ports:
//   clk : sampling clock, rising edge
//   rst : asynchronous active-high reset, clears both flops to 0
//   d   : asynchronous input level
//   q   : synchronised level (two clocks of latency)
// ---------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    // Synchroniser chain: first flop may go metastable, second resolves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/inv_chain_monitor.sv
// ---------------------------------------------------------------------------
// inv_chain_monitor
// Synchronises the inverter-chain output, detects its edges and reports the
// width of every complete high/low pulse in clock cycles. The first partial
// pulse after reset or enable is discarded.
// Ports:
//   clk        : sole clock, rising edge
//   rst        : asynchronous active-high reset
//   din        : chain output, asynchronous to clk
//   en         : measurement enable
//   clr        : synchronous clear of edge_cnt and ovf
//   meas_valid : one-cycle strobe, a pulse just ended
//   meas_level : level of the ended pulse
//   meas_width : width of the ended pulse in cycles (saturating)
//   glitch     : ended pulse was shorter than MIN_W cycles
//   edge_cnt   : edges seen while enabled, wraps
//   ovf        : sticky, a width counter saturated
// ---------------------------------------------------------------------------
module inv_chain_monitor
    import inv_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF,
    parameter int MIN_W  = MIN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              en,
    input  logic              clr,
    output logic              meas_valid,
    output logic              meas_level,
    output logic [CNT_W-1:0]  meas_width,
    output logic              glitch,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic              ovf
);

    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_MIN   = CNT_W'(MIN_W);
    localparam logic [EDGE_W-1:0] EDGE_ZERO = {EDGE_W{1'b0}};
    localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

    logic             w_s;
    logic             r_s_d;
    logic             w_edge;
    logic             w_measuring;
    logic             w_sat;
    logic [CNT_W-1:0] w_cnt_inc;
    mon_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (w_s)
    );

    // Previous synchronised level; tracks even while disabled so that
    // re-enabling never sees a stale difference.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign w_edge      = en & (w_s ^ r_s_d);
    assign w_measuring = en & (r_state != WAIT);
    assign w_cnt_inc   = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);
    // Saturation event: this increment is the one that lands on CNT_MAX.
    assign w_sat       = w_measuring & ~w_edge & (r_cnt != CNT_MAX) & (w_cnt_inc == CNT_MAX);

    // Measurement FSM, width counter and registered measurement outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= WAIT;
            r_cnt      <= CNT_ZERO;
            meas_valid <= 1'b0;
            meas_level <= 1'b0;
            meas_width <= CNT_ZERO;
            glitch     <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (!en) begin
                r_state <= WAIT;
                r_cnt   <= CNT_ZERO;
            end else begin
                case (r_state)
                    WAIT: begin
                        if (w_edge) begin
                            r_state <= w_s ? HIGH : LOW;
                            r_cnt   <= CNT_ONE;
                        end
                    end
                    HIGH, LOW: begin
                        if (w_edge) begin
                            meas_valid <= 1'b1;
                            meas_level <= r_s_d;
                            meas_width <= r_cnt;
                            glitch     <= (r_cnt < CNT_MIN);
                            r_cnt      <= CNT_ONE;
                            r_state    <= w_s ? HIGH : LOW;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= WAIT;
                        r_cnt   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

    // Edge counter; a clear coinciding with an edge keeps that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt <= EDGE_ZERO;
        end else if (clr) begin
            edge_cnt <= w_edge ? EDGE_ONE : EDGE_ZERO;
        end else if (w_edge) begin
            edge_cnt <= edge_cnt + EDGE_ONE;
        end
    end

    // Sticky overflow; a saturation in the clear cycle wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (w_sat) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_chain_monitor.sv
// ---------------------------------------------------------------------------
// tb_inv_chain_monitor
// Scoreboard bench for inv_chain_monitor (CNT_W=4, EDGE_W=16, MIN_W=2).
// The stimulus is a sequence of din segments (level, cycles). A pulse model
// turns level changes into expected measurements pushed on a queue; a
// monitor pops and compares whenever meas_valid is seen.
// ---------------------------------------------------------------------------
module tb_inv_chain_monitor;

    localparam int CNT_W  = 4;
    localparam int EDGE_W = 16;
    localparam int MIN_W  = 2;
    localparam int SAT    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              din;
    logic              en;
    logic              clr;
    logic              meas_valid;
    logic              meas_level;
    logic [CNT_W-1:0]  meas_width;
    logic              glitch;
    logic [EDGE_W-1:0] edge_cnt;
    logic              ovf;

    always #5 clk = ~clk;

    inv_chain_monitor #(.CNT_W(CNT_W), .EDGE_W(EDGE_W), .MIN_W(MIN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .en         (en),
        .clr        (clr),
        .meas_valid (meas_valid),
        .meas_level (meas_level),
        .meas_width (meas_width),
        .glitch     (glitch),
        .edge_cnt   (edge_cnt),
        .ovf        (ovf)
    );

    typedef struct {
        logic lvl;
        int   w;
        logic g;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // pulse model state
    logic              m_lvl;
    int                m_run;
    bit                m_in;
    bit                m_en;
    logic [EDGE_W-1:0] m_edges;
    logic              m_ovf;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // A level change while enabled is an edge; it closes the running pulse.
    task automatic drive(input logic lvl);
        din = lvl;
        if (lvl !== m_lvl && m_en) begin
            m_edges++;
            if (m_in)
                q.push_back('{lvl: m_lvl, w: (m_run > SAT) ? SAT : m_run, g: (m_run < MIN_W)});
            m_in  = 1'b1;
            m_run = 0;
        end
        m_lvl = lvl;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        if (m_in) begin
            m_run += n;
            if (m_run >= SAT) m_ovf = 1'b1;
        end
    endtask

    task automatic seg(input logic lvl, input int n);
        drive(lvl);
        wait_cyc(n);
    endtask

    task automatic set_en(input logic v);
        en   = v;
        m_en = v;
        if (!v) begin
            m_in  = 1'b0;
            m_run = 0;
        end
    endtask

    task automatic check_state(input string nm);
        chk({nm, "_edge_cnt"}, edge_cnt, m_edges);
        chk({nm, "_ovf"}, ovf, m_ovf);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && meas_valid === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_strobe: level=%0b width=%0d, none expected (t=%0t)",
                         meas_level, meas_width, $time);
            end else begin
                e = q.pop_front();
                chk("strobe_level", meas_level, e.lvl);
                chk("strobe_width", meas_width, e.w);
                chk("strobe_glitch", glitch, e.g);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; din = 1'b0; en = 1'b1; clr = 1'b0;
        m_lvl = 1'b0; m_run = 0; m_in = 1'b0; m_en = 1'b1;
        m_edges = '0; m_ovf = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("reset_idle", {meas_valid, meas_level, meas_width, glitch, edge_cnt, ovf}, 64'd0);
        end

        // toggling every 5 cycles
        for (int i = 0; i < 8; i++) seg((i % 2 == 0) ? 1'b1 : 1'b0, 5);
        check_state("toggle");

        // single-cycle high pulse inside a long low
        seg(1'b0, 8);
        seg(1'b1, 1);
        seg(1'b0, 8);
        seg(1'b1, 6);
        check_state("glitch");

        // saturation of the width counter
        seg(1'b0, 6);
        seg(1'b1, 10);
        check_state("ovf_pre");
        seg(1'b1, 10);
        check_state("ovf_sat");
        seg(1'b0, 6);
        check_state("ovf_end");

        // clear while idle
        clr = 1'b1;
        m_edges = '0;
        m_ovf   = 1'b0;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(3);
        check_state("clr");

        // clear in the same cycle as a detected edge (2 clocks after the sample)
        drive(1'b1);
        wait_cyc(2);
        clr = 1'b1;
        m_edges = '0;
        m_edges++;
        wait_cyc(1);
        clr = 1'b0;
        wait_cyc(3);
        check_state("clr_edge");

        // enable dropped mid-high, toggles while disabled, re-enable on stable din
        seg(1'b0, 6);
        seg(1'b1, 4);
        set_en(1'b0);
        seg(1'b1, 5);
        seg(1'b0, 6);
        seg(1'b1, 6);
        set_en(1'b1);
        seg(1'b1, 6);
        check_state("en_reenable");
        seg(1'b0, 5);
        seg(1'b1, 4);
        seg(1'b0, 5);
        check_state("en_after");

        // reset in the middle of a low pulse
        seg(1'b1, 5);
        seg(1'b0, 5);
        chk("pre_rst_queue", q.size(), 64'd0);
        #2 rst = 1'b1;
        #1 chk("rst_outputs", {meas_valid, meas_level, meas_width, glitch, edge_cnt, ovf}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_edges = '0; m_ovf = 1'b0; m_in = 1'b0; m_run = 0; m_lvl = 1'b0;
        seg(1'b0, 3);
        seg(1'b1, 5);
        seg(1'b0, 4);
        seg(1'b1, 4);
        check_state("rst");

        // randomized pulse train
        for (int i = 0; i < 60; i++) seg(~m_lvl, $urandom_range(1, 9));
        seg(~m_lvl, 6);
        check_state("random");
        seg(~m_lvl, 6);
        wait_cyc(4);
        chk("queue_drained", q.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
